// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and defaults for the alarm clock key controller
package alarm_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_ENTRY        = 3'd1,
    KEY_STORED       = 3'd2,
    SHOW_ALARM       = 3'd3,
    SET_ALARM_TIME   = 3'd4,
    SET_CURRENT_TIME = 3'd5,
    KEY_WAITED       = 3'd6
  } state_t;

  localparam int unsigned NOKEY_DEF       = 10;
  localparam int unsigned NUM_DIGITS_DEF  = 4;
  localparam int unsigned TIMEOUT_SEC_DEF = 10;

endpackage

// File: rtl/alarm_sec_timeout.sv
// rtl/alarm_sec_timeout.sv - saturating seconds counter that flags entry inactivity
module alarm_sec_timeout #(
  parameter int unsigned TIMEOUT_SEC = alarm_pkg::TIMEOUT_SEC_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic time_out
);

  localparam logic [7:0] T_MAX = 8'(TIMEOUT_SEC);

  logic [7:0] sec_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sec_cnt <= 8'd0;
    end else if (clear || !enable) begin
      sec_cnt <= 8'd0;
    end else if (tick && (sec_cnt != T_MAX)) begin
      sec_cnt <= sec_cnt + 8'd1;
    end
  end

  assign time_out = (sec_cnt == T_MAX);

endmodule

// File: rtl/alarm_key_ctrl_fsm.sv
// rtl/alarm_key_ctrl_fsm.sv - keypad entry sequencer driving the alarm clock datapath strobes
module alarm_key_ctrl_fsm
  import alarm_pkg::*;
#(
  parameter int unsigned KEY_W        = 4,
  parameter int unsigned NOKEY        = NOKEY_DEF,
  parameter int unsigned NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int unsigned TIMEOUT_SEC  = TIMEOUT_SEC_DEF,
  parameter bit          REQUIRE_FULL = 1'b1,
  localparam int unsigned CW          = $clog2(NUM_DIGITS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             one_second,
  input  logic             time_button,
  input  logic             alarm_button,
  input  logic [KEY_W-1:0] key,
  output logic             shift,
  output logic             show_new_time,
  output logic             show_a,
  output logic             load_new_a,
  output logic             load_new_c,
  output logic             reset_count,
  output logic [CW-1:0]    digit_count
);

  localparam logic [KEY_W-1:0] NOKEY_CODE = KEY_W'(NOKEY);
  localparam logic [CW-1:0]    FULL_CNT   = CW'(NUM_DIGITS);

  state_t state, next_state;
  logic   time_out;
  logic   key_down;
  logic   commit_ok;

  assign key_down  = (key != NOKEY_CODE);
  assign commit_ok = REQUIRE_FULL ? (digit_count == FULL_CNT) : (digit_count != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SHOW_TIME;
    end else begin
      state <= next_state;
    end
  end

  // Count is cleared on the edge that returns to SHOW_TIME, so aborts and commits share one path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digit_count <= '0;
    end else if (next_state == SHOW_TIME) begin
      digit_count <= '0;
    end else if (state == KEY_STORED) begin
      digit_count <= digit_count + CW'(1);
    end
  end

  always_comb begin
    next_state = SHOW_TIME;
    unique case (state)
      SHOW_TIME: begin
        if (alarm_button)  next_state = SHOW_ALARM;
        else if (key_down) next_state = KEY_STORED;
        else               next_state = SHOW_TIME;
      end
      KEY_STORED: next_state = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_down)     next_state = KEY_ENTRY;
        else if (time_out) next_state = SHOW_TIME;
        else               next_state = KEY_WAITED;
      end
      KEY_ENTRY: begin
        if (alarm_button && commit_ok)                next_state = SET_ALARM_TIME;
        else if (time_button && commit_ok)            next_state = SET_CURRENT_TIME;
        else if (time_out)                            next_state = SHOW_TIME;
        else if (key_down && (digit_count < FULL_CNT)) next_state = KEY_STORED;
        else                                          next_state = KEY_ENTRY;
      end
      SHOW_ALARM:       next_state = alarm_button ? SHOW_ALARM : SHOW_TIME;
      SET_ALARM_TIME:   next_state = SHOW_TIME;
      SET_CURRENT_TIME: next_state = SHOW_TIME;
      default:          next_state = SHOW_TIME;
    endcase
  end

  always_comb begin
    shift         = 1'b0;
    show_new_time = 1'b0;
    show_a        = 1'b0;
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    reset_count   = 1'b0;
    unique case (state)
      KEY_STORED: begin
        shift         = 1'b1;
        show_new_time = 1'b1;
      end
      KEY_WAITED:       show_new_time = 1'b1;
      KEY_ENTRY:        show_new_time = 1'b1;
      SHOW_ALARM:       show_a        = 1'b1;
      SET_ALARM_TIME:   load_new_a    = 1'b1;
      SET_CURRENT_TIME: begin
        load_new_c  = 1'b1;
        reset_count = 1'b1;
      end
      default: ;
    endcase
  end

  alarm_sec_timeout #(
    .TIMEOUT_SEC(TIMEOUT_SEC)
  ) u_sec_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (next_state != state),
    .enable  ((state == KEY_WAITED) || (state == KEY_ENTRY)),
    .tick    (one_second),
    .time_out(time_out)
  );

endmodule
